// File: rtl/hc595_chain_drv.sv
// ---------------------------------------------------------------------------
// hc595_chain_drv
//
// Serial driver for a daisy chain of 74HC595 shift registers feeding the
// digital-tube display. A chain word is accepted through a valid/ready
// handshake, shifted out on ds/shcp at a programmable bit rate and bit order,
// and then latched into the 595 storage registers with an stcp pulse. The 595
// output enable stays inactive until the first complete frame has latched.
//
// Parameters
//   DATA_W     total chain bits (8 per 595), 1..64
//   CLK_DIV    clk cycles per shcp half-period, >= 1
//   LATCH_W    clk cycles stcp is held high, >= 1
//   MSB_FIRST  1: load_data[DATA_W-1] shifted first, 0: load_data[0] first
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active-low
//   load_valid  load_data is valid
//   load_data   chain word, sampled only on the accept cycle
//   load_ready  word can be accepted (high exactly in IDLE)
//   oe_en       display enable request
//   busy        inverse of load_ready
//   done        one-cycle pulse on the first IDLE cycle after the latch
//   ds          595 serial data
//   shcp        595 shift clock
//   stcp        595 storage (latch) clock
//   oe_n        595 output enable, active-low, registered
// ---------------------------------------------------------------------------
module hc595_chain_drv #(
   parameter int DATA_W    = 16,
   parameter int CLK_DIV   = 4,
   parameter int LATCH_W   = 2,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   input  logic              oe_en,
   output logic              busy,
   output logic              done,
   output logic              ds,
   output logic              shcp,
   output logic              stcp,
   output logic              oe_n
);

   localparam int BIT_W = $clog2(DATA_W + 1);
   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam int LAT_W = $clog2(LATCH_W + 1);

   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
   localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);
   localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(LATCH_W - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      LATCH
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] sreg;
   logic [DATA_W-1:0] sreg_next;
   logic [BIT_W-1:0]  bit_cnt;
   logic [DIV_W-1:0]  div_cnt;
   logic [LAT_W-1:0]  lat_cnt;
   logic              latched_once;
   logic              first_bit;
   logic              bit_next;

   // The bit presented on ds is always the end of sreg nearest the output;
   // shifting towards that end exposes the following bit.
   always_comb begin
      sreg_next = '0;
      bit_next  = 1'b0;
      first_bit = 1'b0;
      if (MSB_FIRST) begin
         sreg_next = sreg << 1;
         bit_next  = sreg_next[DATA_W-1];
         first_bit = load_data[DATA_W-1];
      end else begin
         sreg_next = sreg >> 1;
         bit_next  = sreg_next[0];
         first_bit = load_data[0];
      end
   end

   always_comb begin
      load_ready = (state == IDLE);
      busy       = ~load_ready;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         sreg         <= '0;
         bit_cnt      <= '0;
         div_cnt      <= '0;
         lat_cnt      <= '0;
         latched_once <= 1'b0;
         done         <= 1'b0;
         ds           <= 1'b0;
         shcp         <= 1'b0;
         stcp         <= 1'b0;
         oe_n         <= 1'b1;
      end else begin
         done <= 1'b0;
         oe_n <= ~(oe_en & latched_once);

         case (state)
            IDLE: begin
               if (load_valid) begin
                  sreg    <= load_data;
                  bit_cnt <= '0;
                  div_cnt <= '0;
                  ds      <= first_bit;
                  shcp    <= 1'b0;
                  state   <= SHIFT;
               end
            end

            // div_cnt times each half-period; shcp itself records which half
            // of the bit period is running, so the bit advances only at the
            // end of a high phase.
            SHIFT: begin
               if (div_cnt == LAST_DIV) begin
                  div_cnt <= '0;
                  if (!shcp) begin
                     shcp <= 1'b1;
                  end else if (bit_cnt == LAST_BIT) begin
                     shcp    <= 1'b0;
                     ds      <= 1'b0;
                     stcp    <= 1'b1;
                     lat_cnt <= '0;
                     state   <= LATCH;
                  end else begin
                     shcp    <= 1'b0;
                     bit_cnt <= bit_cnt + 1'b1;
                     sreg    <= sreg_next;
                     ds      <= bit_next;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end

            LATCH: begin
               if (lat_cnt == LAST_LAT) begin
                  stcp         <= 1'b0;
                  done         <= 1'b1;
                  latched_once <= 1'b1;
                  state        <= IDLE;
               end else begin
                  lat_cnt <= lat_cnt + 1'b1;
               end
            end

            default: begin
               state <= IDLE;
               shcp  <= 1'b0;
               stcp  <= 1'b0;
               ds    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hc595_chain_drv.sv
// ---------------------------------------------------------------------------
// tb_hc595_chain_drv
//
// Self-checking bench for hc595_chain_drv. Instance a uses the default
// parameters (16 bits, MSB first); instance b is an 8-bit LSB-first chain.
// Expected waveforms come from the frame timing rules (bit k occupies
// 2*CLK_DIV cycles starting one cycle after accept, low half first, then
// LATCH_W cycles of stcp, then done) and from a queue of the bits the chain
// should receive in order. Outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_hc595_chain_drv;

   logic        clk = 1'b0;
   logic        rst;
   logic        oe_en;

   logic        valid_a;
   logic [15:0] data_a;
   logic        ready_a, busy_a, done_a, ds_a, shcp_a, stcp_a, oe_n_a;

   logic        valid_b;
   logic [7:0]  data_b;
   logic        ready_b, busy_b, done_b, ds_b, shcp_b, stcp_b, oe_n_b;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc   = 0;
   logic        lo_model;   // model of latched_once for instance a
   logic        exp_oe;     // model of oe_n for instance a in current cycle

   always #5 clk = ~clk;

   hc595_chain_drv #(
      .DATA_W(16), .CLK_DIV(4), .LATCH_W(2), .MSB_FIRST(1'b1)
   ) dut_a (
      .clk(clk), .rst(rst), .load_valid(valid_a), .load_data(data_a),
      .load_ready(ready_a), .oe_en(oe_en), .busy(busy_a), .done(done_a),
      .ds(ds_a), .shcp(shcp_a), .stcp(stcp_a), .oe_n(oe_n_a)
   );

   hc595_chain_drv #(
      .DATA_W(8), .CLK_DIV(4), .LATCH_W(2), .MSB_FIRST(1'b0)
   ) dut_b (
      .clk(clk), .rst(rst), .load_valid(valid_b), .load_data(data_b),
      .load_ready(ready_b), .oe_en(oe_en), .busy(busy_b), .done(done_b),
      .ds(ds_b), .shcp(shcp_b), .stcp(stcp_b), .oe_n(oe_n_b)
   );

   // Advance to the next falling edge and update the oe_n model with the
   // inputs that were applied at the rising edge in between.
   task automatic step();
      logic nxt;
      nxt = ~(oe_en & lo_model);
      @(negedge clk);
      cyc++;
      exp_oe = rst ? nxt : 1'b1;
   endtask

   task automatic accept_a(input logic [15:0] w);
      n_cmp++;
      if (ready_a !== 1'b1) begin
         n_err++;
         $display("FAIL accept_a cyc=%0d load_ready got=%b want=1", cyc, ready_a);
      end
      valid_a = 1'b1;
      data_a  = w;
   endtask

   // Observe one full frame of instance a, starting the cycle after accept.
   task automatic frame_a(input logic [15:0] w, input bit hold,
                          input bit scramble, input bit toggle);
      logic       q[$];
      logic       prev, b;
      logic [5:0] got, want;
      int         k;
      for (int i = 0; i < 16; i++) q.push_back(w[15-i]);
      prev = 1'b0;
      for (int o = 1; o <= 131; o++) begin
         step();
         k = (o - 1) / 8;
         want[5] = (o == 131);
         want[4] = (o != 131);
         want[3] = (o == 131);
         want[2] = (o <= 128) && (((o - 1) % 8) >= 4);
         want[1] = (o >= 129) && (o <= 130);
         want[0] = (o <= 128) ? w[15-k] : 1'b0;
         got = {ready_a, busy_a, done_a, shcp_a, stcp_a, ds_a};
         n_cmp++;
         if (got !== want) begin
            n_err++;
            $display("FAIL a_outputs cyc=%0d off=%0d {rdy,bsy,done,shcp,stcp,ds} got=%b want=%b",
                     cyc, o, got, want);
         end
         n_cmp++;
         if (oe_n_a !== exp_oe) begin
            n_err++;
            $display("FAIL a_oe_n cyc=%0d off=%0d got=%b want=%b", cyc, o, oe_n_a, exp_oe);
         end
         if (shcp_a === 1'b1 && prev === 1'b0) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL a_extra_rise cyc=%0d got=rise want=none", cyc);
            end else begin
               b = q.pop_front();
               if (ds_a !== b) begin
                  n_err++;
                  $display("FAIL a_ds_at_rise cyc=%0d bit=%0d got=%b want=%b",
                           cyc, 15 - q.size(), ds_a, b);
               end
            end
         end
         prev = shcp_a;
         if (o == 131) lo_model = 1'b1;
         if (!hold && o == 1) valid_a = 1'b0;
         if (scramble && o < 131) data_a = 16'($urandom);
         if (toggle && o == 20) oe_en = 1'b0;
         if (toggle && o == 40) oe_en = 1'b1;
      end
      n_cmp++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL a_rise_count got=%0d want=16", 16 - q.size());
      end
   endtask

   // One frame on instance b (8 bits, LSB first).
   task automatic frame_b(input logic [7:0] w);
      logic       q[$];
      logic       prev, b;
      logic [5:0] got, want;
      n_cmp++;
      if (ready_b !== 1'b1) begin
         n_err++;
         $display("FAIL accept_b cyc=%0d load_ready got=%b want=1", cyc, ready_b);
      end
      valid_b = 1'b1;
      data_b  = w;
      for (int i = 0; i < 8; i++) q.push_back(w[i]);
      prev = 1'b0;
      for (int o = 1; o <= 67; o++) begin
         step();
         want[5] = (o == 67);
         want[4] = (o != 67);
         want[3] = (o == 67);
         want[2] = (o <= 64) && (((o - 1) % 8) >= 4);
         want[1] = (o >= 65) && (o <= 66);
         want[0] = (o <= 64) ? w[(o-1)/8] : 1'b0;
         got = {ready_b, busy_b, done_b, shcp_b, stcp_b, ds_b};
         n_cmp++;
         if (got !== want) begin
            n_err++;
            $display("FAIL b_outputs cyc=%0d off=%0d {rdy,bsy,done,shcp,stcp,ds} got=%b want=%b",
                     cyc, o, got, want);
         end
         if (shcp_b === 1'b1 && prev === 1'b0) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL b_extra_rise cyc=%0d got=rise want=none", cyc);
            end else begin
               b = q.pop_front();
               if (ds_b !== b) begin
                  n_err++;
                  $display("FAIL b_ds_at_rise cyc=%0d bit=%0d got=%b want=%b",
                           cyc, 7 - q.size(), ds_b, b);
               end
            end
         end
         prev = shcp_b;
         if (o == 1) valid_b = 1'b0;
      end
      n_cmp++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL b_rise_count got=%0d want=8", 8 - q.size());
      end
   endtask

   // Instance a idle for one cycle: everything quiet, oe_n per model.
   task automatic idle_a(input string tag);
      logic [5:0] got;
      step();
      got = {ready_a, busy_a, done_a, shcp_a, stcp_a, ds_a};
      n_cmp++;
      if (got !== 6'b100000 || oe_n_a !== exp_oe) begin
         n_err++;
         $display("FAIL %s cyc=%0d outputs got=%b oe_n=%b want=100000 oe_n=%b",
                  tag, cyc, got, oe_n_a, exp_oe);
      end
   endtask

   task automatic test_reset();
      logic [6:0] ga, gb;
      for (int i = 0; i < 16; i++) begin
         if (i == 8) rst = 1'b1;
         step();
         ga = {ready_a, busy_a, done_a, shcp_a, stcp_a, ds_a, oe_n_a};
         gb = {ready_b, busy_b, done_b, shcp_b, stcp_b, ds_b, oe_n_b};
         n_cmp++;
         if (ga !== 7'b1000001 || gb !== 7'b1000001) begin
            n_err++;
            $display("FAIL reset_state cyc=%0d a=%b b=%b want=1000001", cyc, ga, gb);
         end
      end
   endtask

   task automatic test_defaults();
      accept_a(16'hA5C3);
      frame_a(16'hA5C3, 1'b0, 1'b0, 1'b0);
      step();
      n_cmp++;
      if (oe_n_a !== 1'b0) begin
         n_err++;
         $display("FAIL first_enable cyc=%0d oe_n got=%b want=0", cyc, oe_n_a);
      end
   endtask

   task automatic test_lsb_first();
      frame_b(8'h01);
      for (int i = 0; i < 3; i++) frame_b(8'($urandom));
   endtask

   task automatic test_back_to_back();
      accept_a(16'h1234);
      frame_a(16'h1234, 1'b1, 1'b1, 1'b0);
      accept_a(16'hFFFF);
      frame_a(16'hFFFF, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) idle_a("b2b_quiet");
   endtask

   task automatic test_reset_midframe();
      logic [6:0] got;
      logic [15:0] w;
      w = 16'($urandom);
      accept_a(w);
      for (int o = 1; o <= 50; o++) begin
         step();
         if (o == 1) valid_a = 1'b0;
      end
      rst = 1'b0;
      #1;
      got = {ready_a, busy_a, done_a, shcp_a, stcp_a, ds_a, oe_n_a};
      n_cmp++;
      if (got !== 7'b1000001) begin
         n_err++;
         $display("FAIL async_reset cyc=%0d got=%b want=1000001", cyc, got);
      end
      lo_model = 1'b0;
      exp_oe   = 1'b1;
      for (int i = 0; i < 4; i++) idle_a("reset_hold");
      rst = 1'b1;
      idle_a("reset_release");
      accept_a(16'h00FF);
      frame_a(16'h00FF, 1'b0, 1'b0, 1'b0);
      step();
      n_cmp++;
      if (oe_n_a !== 1'b0) begin
         n_err++;
         $display("FAIL reenable cyc=%0d oe_n got=%b want=0", cyc, oe_n_a);
      end
   endtask

   task automatic test_oe_toggle();
      logic [15:0] w;
      w = 16'($urandom);
      accept_a(w);
      frame_a(w, 1'b0, 1'b0, 1'b1);
      idle_a("oe_after");
   endtask

   task automatic test_random();
      logic [15:0] w;
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, 3)) idle_a("rand_gap");
         w = 16'($urandom);
         accept_a(w);
         frame_a(w, 1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      rst      = 1'b0;
      oe_en    = 1'b1;
      valid_a  = 1'b0;
      data_a   = '0;
      valid_b  = 1'b0;
      data_b   = '0;
      lo_model = 1'b0;
      exp_oe   = 1'b1;
      test_reset();
      test_defaults();
      test_lsb_first();
      test_back_to_back();
      test_reset_midframe();
      test_oe_toggle();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
